pattern_generator: RTL and testbench
====================================

PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 SHALL have parameter: WIDTH, 16, pattern register width in bits (>=2).
REQ-002 SHALL have parameter: CNT_W, 8, width of the pass-repeat counter.
REQ-003 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: load  in  1  captures pattern, length and mode when idle.
REQ-006 SHALL have port: pattern  in  WIDTH  bit sequence; MSB is emitted first.
REQ-007 SHALL have port: length  in  $clog2(WIDTH)  active sequence length minus one (0 = 1 bit).
REQ-008 SHALL have port: mode  in  1  0 = loop (circular), 1 = one-shot (single pass).
REQ-009 SHALL have port: start  in  1  begins emission when idle.
REQ-010 SHALL have port: stop  in  1  aborts emission.
REQ-011 SHALL have port: repeats  in  CNT_W  pass count for loop mode; present only with PATGEN_REPEAT_EN.
REQ-012 SHALL have port: shift_out  out  1  serial pattern bit.
REQ-013 SHALL have port: busy  out  1  high while in RUN.
REQ-014 SHALL have port: done  out  1  one-cycle pulse on natural completion.
REQ-015 SHALL have port: bit_index  out  $clog2(WIDTH)  index of the bit currently on shift_out.

Function
REQ-016 SHALL implement the FSM states IDLE and RUN.
REQ-017 SHALL, in IDLE with load=1, register pattern, length and mode (and repeats) at the clock edge; load SHALL be ignored in RUN.
REQ-018 SHALL, in IDLE with start=1, enter RUN at that edge with bit_index=0; when load and start are both high, the newly loaded values SHALL be used.
REQ-019 SHALL drive shift_out = busy AND pat_reg[WIDTH-1-bit_index], decoded from registers only, with no input-to-output combinational path.
REQ-020 SHALL drive the first bit on shift_out in the cycle after start is sampled (latency 1).
REQ-021 SHALL, in RUN, increment bit_index each cycle and wrap it to 0 after reaching len_reg, which completes one pass.
REQ-022 SHALL, in loop mode, run indefinitely until stop (subject to REQ-030/031).
REQ-023 SHALL, in one-shot mode, return to IDLE at the edge ending the last bit of the pass, and assert done for exactly the following cycle.
REQ-024 SHALL, on stop=1 in RUN, enter IDLE at the next edge with done held 0; stop SHALL have priority over wrap and completion.
REQ-025 SHALL ignore start while in RUN, and ignore stop while in IDLE.
REQ-026 SHALL treat length values above WIDTH-1 as saturated to WIDTH-1.

Reset
REQ-027 SHALL, when reset_n=0, immediately force: state IDLE, busy=0, done=0, shift_out=0, bit_index=0, pat_reg=0, len_reg=WIDTH-1, mode_reg=0, and the pass counter to 0.
REQ-028 SHALL, on reset asserted mid-run, abort emission without a done pulse; the first post-reset start with no prior load SHALL emit all zeros.

Configuration
REQ-029 SHALL compile the repeat feature under macro PATGEN_REPEAT_EN.
REQ-030 SHALL, with PATGEN_REPEAT_EN defined, in loop mode with repeats=N>0, stop after exactly N passes with a done pulse; repeats=0 SHALL mean infinite.
REQ-031 SHALL, without PATGEN_REPEAT_EN, omit the repeats port and the pass counter, so that loop mode runs until stop.

Structure
REQ-032 SHALL place the state enum (IDLE, RUN) and the mode encodings (LOOP=0, ONESHOT=1) in shared package patgen_pkg.
REQ-033 SHALL be a single module; no sub-module is required.

Verification
REQ-034 SHALL verify: WIDTH=16, pattern=16'hAAAA, length=15, loop -> shift_out toggles 1,0 every cycle for 64 cycles; done never asserted.
REQ-035 SHALL verify: pattern=16'h8080, length=15, loop -> one high cycle followed by 7 low cycles, repeating (1/7 pulse-gap).
REQ-036 SHALL verify: pattern=16'hC000, length=2, loop -> sequence 1,1,0 with period 3; bit_index cycles 0,1,2.
REQ-037 SHALL verify: pattern=16'hF000, length=3, one-shot -> 1,1,1,1, then busy=0, done=1 for one cycle, shift_out=0.
REQ-038 SHALL verify: stop asserted at bit_index=5, and separately reset_n pulsed low at bit_index=5 -> IDLE, shift_out=0, no done pulse.
REQ-039 SHALL verify, with PATGEN_REPEAT_EN: pattern=16'h8000, length=3, repeats=3 -> three pulses 4 cycles apart, then done for exactly one cycle.

Source files
------------

// File: rtl/patgen_pkg.sv
// Shared types for the serial pattern generator.
// FSM state and pattern mode encodings.
package patgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic LOOP    = 1'b0;
  localparam logic ONESHOT = 1'b1;

endpackage

// File: rtl/pattern_generator.sv
// Serial pattern generator: shifts a loaded pattern out MSB first.
// Optional pass-repeat limit in loop mode: PATGEN_REPEAT_EN.
module pattern_generator
  import patgen_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [IW-1:0]    length,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
`ifdef PATGEN_REPEAT_EN
  input  logic [CNT_W-1:0] repeats,
`endif
  output logic             shift_out,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    bit_index
);

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    len_q, len_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic [IW-1:0]    len_sat;
  logic [IW-1:0]    pos;

`ifdef PATGEN_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Clamp requested length so indexing never leaves the pattern.
  always_comb begin
    len_sat = length;
    if (32'(length) > WIDTH - 1) len_sat = LAST;
  end

  // Next-state and datapath decode for the IDLE/RUN machine.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
`ifdef PATGEN_REPEAT_EN
    rep_d   = rep_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          pat_d  = pattern;
          len_d  = len_sat;
          mode_d = mode;
`ifdef PATGEN_REPEAT_EN
          rep_d  = repeats;
`endif
        end
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
`ifdef PATGEN_REPEAT_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (idx_q == len_q) begin
          idx_d = '0;
          if (mode_q == ONESHOT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`ifdef PATGEN_REPEAT_EN
          else if (rep_q != '0 &&
                   cnt_q == rep_q - CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= LAST;
      mode_q  <= LOOP;
      done_q  <= 1'b0;
`ifdef PATGEN_REPEAT_EN
      rep_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
`ifdef PATGEN_REPEAT_EN
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = (state_q == RUN);
    pos       = LAST - idx_q;
    shift_out = busy & pat_q[pos];
    done      = done_q;
    bit_index = idx_q;
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator.
// Model tracks cycles-in-run arithmetically.
module tb_pattern_generator;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int IW    = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic [IW-1:0]    length;
  logic             mode;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] repeats;
  logic             shift_out;
  logic             busy;
  logic             done;
  logic [IW-1:0]    bit_index;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [WIDTH-1:0] m_pat  = '0;
  int               m_len  = WIDTH - 1;
  bit               m_mode = 1'b0;
  int               m_rep  = 0;
  bit               m_run  = 1'b0;
  bit               m_done = 1'b0;
  int               m_k    = 0;

  pattern_generator #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .pattern  (pattern),
    .length   (length),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
`ifdef PATGEN_REPEAT_EN
    .repeats  (repeats),
`endif
    .shift_out(shift_out),
    .busy     (busy),
    .done     (done),
    .bit_index(bit_index)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: k cycles into a run; index and pass are k mod/div length.
  always @(posedge clock or negedge reset_n) begin : model
    int nk;
    int need;
    if (!reset_n) begin
      m_pat  <= '0;
      m_len  <= WIDTH - 1;
      m_mode <= 1'b0;
      m_rep  <= 0;
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (load) begin
          m_pat  <= pattern;
          m_len  <= (int'(length) > WIDTH - 1) ?
                    WIDTH - 1 : int'(length);
          m_mode <= mode;
`ifdef PATGEN_REPEAT_EN
          m_rep  <= int'(repeats);
`else
          m_rep  <= 0;
`endif
        end
        if (start) begin
          m_run <= 1'b1;
          m_k   <= 0;
        end
      end else if (stop) begin
        m_run <= 1'b0;
      end else begin
        nk   = m_k + 1;
        need = m_mode ? 1 : m_rep;
        if (need != 0 && nk == need * (m_len + 1)) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
        m_k <= nk;
      end
    end
  end

  // Compare DUT against model every cycle.
  always @(negedge clock) begin : cmp
    int ei;
    int eso;
    if (cmp_en) begin
      ei  = m_run ? (m_k % (m_len + 1)) : 0;
      eso = m_run ? int'(m_pat[WIDTH-1-ei]) : 0;
      chk("cmp_busy", int'(busy), int'(m_run));
      chk("cmp_done", int'(done), int'(m_done));
      chk("cmp_idx", int'(bit_index), ei);
      chk("cmp_so", int'(shift_out), eso);
    end
  end

  task automatic go(input logic [WIDTH-1:0] p,
                    input int l,
                    input bit md,
                    input int rp);
    load    = 1'b1;
    start   = 1'b1;
    pattern = p;
    length  = IW'(l);
    mode    = md;
    repeats = CNT_W'(rp);
    tick();
    load  = 1'b0;
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("halt_busy", int'(busy), 0);
    chk("halt_done", int'(done), 0);
  endtask

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    pattern = '0;
    length  = '0;
    mode    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    repeats = '0;
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_so", int'(shift_out), 0);
    chk("rst_idx", int'(bit_index), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // AAAA loop: alternating 1,0 for 64 cycles.
    go(16'hAAAA, 15, 1'b0, 0);
    for (int i = 0; i < 64; i++) begin
      chk("aaaa_so", int'(shift_out), (i % 2 == 0));
      chk("aaaa_done", int'(done), 0);
      tick();
    end
    halt();

    // 8080 loop, stop held with start in IDLE.
    stop = 1'b1;
    go(16'h8080, 15, 1'b0, 0);
    stop = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("8080_so", int'(shift_out), (i % 8 == 0));
      tick();
    end
    halt();

    // C000 length 2: 1,1,0; load/start ignored in RUN.
    go(16'hC000, 2, 1'b0, 0);
    for (int i = 0; i < 9; i++) begin
      chk("c000_so", int'(shift_out), (i % 3 != 2));
      chk("c000_idx", int'(bit_index), i % 3);
      if (i == 4) begin
        load    = 1'b1;
        start   = 1'b1;
        pattern = 16'h0000;
        length  = 4'd0;
        mode    = 1'b1;
      end
      tick();
      load  = 1'b0;
      start = 1'b0;
    end
    halt();

    // F000 length 3 one-shot.
    go(16'hF000, 3, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("f000_so", int'(shift_out), 1);
      chk("f000_busy", int'(busy), 1);
      tick();
    end
    chk("f000_end_busy", int'(busy), 0);
    chk("f000_end_done", int'(done), 1);
    chk("f000_end_so", int'(shift_out), 0);
    tick();
    chk("f000_done_once", int'(done), 0);
    tick();

    // Stop at bit_index 5.
    go(16'hFFFF, 15, 1'b0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("stop_at5_idx", int'(bit_index), 5);
    halt();
    chk("stop_so", int'(shift_out), 0);
    tick();
    chk("stop_no_done", int'(done), 0);

    // Reset pulsed at bit_index 5.
    go(16'hFFFF, 15, 1'b0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("rst5_idx", int'(bit_index), 5);
    reset_n = 1'b0;
    #1;
    chk("rst5_busy", int'(busy), 0);
    chk("rst5_so", int'(shift_out), 0);
    chk("rst5_idx0", int'(bit_index), 0);
    tick();
    chk("rst5_done", int'(done), 0);
    reset_n = 1'b1;
    tick();
    chk("rst5_done2", int'(done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("zero_so", int'(shift_out), 0);
      chk("zero_idx", int'(bit_index), i % 16);
      tick();
    end
    halt();

`ifdef PATGEN_REPEAT_EN
    // 8000 length 3, three passes then done.
    go(16'h8000, 3, 1'b0, 3);
    for (int i = 0; i < 12; i++) begin
      chk("rep_so", int'(shift_out), (i % 4 == 0));
      chk("rep_busy", int'(busy), 1);
      tick();
    end
    chk("rep_end_busy", int'(busy), 0);
    chk("rep_end_done", int'(done), 1);
    tick();
    chk("rep_done_once", int'(done), 0);
    tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
